// File: rtl/nes_bus_ctrl_if.sv
// Host command port, CPU bus and memory port of the NES bus controller.
// The controller connects through the slave modport; its environment uses master.
interface nes_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              host_valid;
    logic              host_ready;
    logic [7:0]        host_op;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic [7:0]        host_rdata;
    logic              host_rvalid;

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_write;
    logic [7:0]        cpu_dout;
    logic              cpu_sync;
    logic [7:0]        cpu_din;
    logic              cpu_ready;
    logic              cpu_reset;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [7:0]        mem_in;
    logic [7:0]        mem_out;

    modport slave (
        input  host_valid, host_op, host_addr, host_wdata,
        input  cpu_addr, cpu_write, cpu_dout, cpu_sync,
        input  mem_out,
        output host_ready, host_rdata, host_rvalid,
        output cpu_din, cpu_ready, cpu_reset,
        output mem_addr, mem_write, mem_in
    );

    modport master (
        output host_valid, host_op, host_addr, host_wdata,
        output cpu_addr, cpu_write, cpu_dout, cpu_sync,
        output mem_out,
        input  host_ready, host_rdata, host_rvalid,
        input  cpu_din, cpu_ready, cpu_reset,
        input  mem_addr, mem_write, mem_in
    );
endinterface

// File: rtl/nes_bus_ctrl.sv
// NES bus controller: host command decode, 6502 reset sequencing, host/CPU memory arbitration.
// Define NES_BREAKPOINT_EN to add the opcode-fetch breakpoint (SET_BRK, brk_hit).
module nes_bus_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    nes_bus_ctrl_if.slave bus,
    output logic          running,
    output logic          brk_hit
);
    localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        PAUSED,
        RUN,
        STEP,
        HOST_WR,
        HOST_RD,
        HOST_RD_WAIT,
        REFILL
    } state_t;

    typedef enum logic [7:0] {
        OP_RESET_CPU = 8'd0,
        OP_START     = 8'd1,
        OP_PAUSE     = 8'd2,
        OP_WRITE_MEM = 8'd3,
        OP_READ_MEM  = 8'd4,
        OP_STEP      = 8'd5,
        OP_SET_BRK   = 8'd6
    } op_t;

    state_t            state, state_nx;
    state_t            resume, resume_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] haddr;
    logic [7:0]        hwdata;
    logic [7:0]        rdata_q;
    logic              moved;
    logic              cmd_open;
    logic              accept;
    logic              step_stop;
    logic              brk_stop;
    logic              stop;

    assign cmd_open  = state inside {PAUSED, RUN, STEP};
    assign accept    = bus.host_valid && cmd_open;
    // moved guarantees at least one executed CPU cycle after START/STEP before a stop can fire
    assign step_stop = (state == STEP) && moved && bus.cpu_sync;
    assign stop      = step_stop || brk_stop;

`ifdef NES_BREAKPOINT_EN
    logic [ADDR_W-1:0] brk_addr;
    logic              brk_en;
    logic              brk_hit_q;

    assign brk_stop = (state == RUN) && moved && bus.cpu_sync && brk_en
                      && (bus.cpu_addr == brk_addr);
    assign brk_hit  = brk_hit_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brk_addr  <= '0;
            brk_en    <= 1'b0;
            brk_hit_q <= 1'b0;
        end else begin
            if (accept && (bus.host_op == OP_SET_BRK)) begin
                if (bus.host_wdata[0]) begin
                    brk_addr <= bus.host_addr;
                    brk_en   <= 1'b1;
                end else begin
                    brk_en   <= 1'b0;
                end
            end
            if (accept && (bus.host_op inside {OP_START, OP_STEP, OP_RESET_CPU}))
                brk_hit_q <= 1'b0;
            else if (brk_stop)
                brk_hit_q <= 1'b1;
        end
    end
`else
    assign brk_stop = 1'b0;
    assign brk_hit  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RST_HOLD;
            resume  <= PAUSED;
            cnt     <= CNT_W'(RESET_CYCLES);
            haddr   <= '0;
            hwdata  <= '0;
            rdata_q <= '0;
            moved   <= 1'b0;
        end else begin
            state  <= state_nx;
            resume <= resume_nx;
            cnt    <= cnt_nx;
            if (accept) begin
                haddr  <= bus.host_addr;
                hwdata <= bus.host_wdata;
            end
            if (state == HOST_RD_WAIT)
                rdata_q <= bus.mem_out;
            if (accept && (bus.host_op inside {OP_START, OP_STEP}))
                moved <= 1'b0;
            else if (bus.cpu_ready)
                moved <= 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        resume_nx = resume;
        cnt_nx    = cnt;
        case (state)
            RST_HOLD: begin
                if (cnt <= CNT_W'(1))
                    state_nx = PAUSED;
                else
                    cnt_nx = cnt - 1'b1;
            end
            PAUSED, RUN, STEP: begin
                if (stop)
                    state_nx = PAUSED;
                if (accept) begin
                    case (bus.host_op)
                        OP_RESET_CPU: begin
                            state_nx  = RST_HOLD;
                            cnt_nx    = CNT_W'(RESET_CYCLES);
                            resume_nx = PAUSED;
                        end
                        OP_START: state_nx = RUN;
                        OP_PAUSE: state_nx = PAUSED;
                        OP_STEP:  state_nx = STEP;
                        // a stop coinciding with a host access resumes into PAUSED
                        OP_WRITE_MEM: begin
                            state_nx  = HOST_WR;
                            resume_nx = stop ? PAUSED : state;
                        end
                        OP_READ_MEM: begin
                            state_nx  = HOST_RD;
                            resume_nx = stop ? PAUSED : state;
                        end
                        default: ;
                    endcase
                end
            end
            HOST_WR, HOST_RD_WAIT: state_nx = (resume == PAUSED) ? PAUSED : REFILL;
            HOST_RD:               state_nx = HOST_RD_WAIT;
            REFILL:                state_nx = resume;
            default:               state_nx = RST_HOLD;
        endcase
    end

    always_comb begin
        bus.host_ready  = 1'b0;
        bus.host_rvalid = 1'b0;
        bus.host_rdata  = rdata_q;
        bus.cpu_din     = bus.mem_out;
        bus.cpu_ready   = 1'b0;
        bus.cpu_reset   = 1'b0;
        bus.mem_addr    = bus.cpu_addr;
        bus.mem_write   = 1'b0;
        bus.mem_in      = bus.cpu_dout;
        running         = 1'b0;
        case (state)
            RST_HOLD: bus.cpu_reset = 1'b1;
            PAUSED:   bus.host_ready = 1'b1;
            RUN, STEP: begin
                bus.host_ready = 1'b1;
                running        = 1'b1;
                bus.cpu_ready  = !stop;
                bus.mem_write  = bus.cpu_write && !stop;
            end
            HOST_WR: begin
                bus.mem_addr  = haddr;
                bus.mem_write = 1'b1;
                bus.mem_in    = hwdata;
            end
            HOST_RD: bus.mem_addr = haddr;
            HOST_RD_WAIT: begin
                bus.host_rvalid = 1'b1;
                bus.host_rdata  = bus.mem_out;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_nes_bus_ctrl.sv
// Directed bench for nes_bus_ctrl: scripted CPU, registered memory and a cycle-level
// reference model built from a schedule of host-access cycles.
module tb_nes_bus_ctrl;
    localparam int RC = 4;
    localparam logic [7:0] OP_RESET = 8'd0, OP_START = 8'd1, OP_PAUSE = 8'd2,
                           OP_WRITE = 8'd3, OP_READ  = 8'd4, OP_STEP  = 8'd5,
                           OP_BRK   = 8'd6;
    localparam int K_WR = 0, K_RD = 1, K_RDW = 2, K_FILL = 3;

    typedef struct {
        int         kind;
        logic [15:0] a;
        logic [7:0]  d;
    } slot_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic running, brk_hit;
    int   tests = 0;
    int   fails = 0;

    nes_bus_ctrl_if #(.ADDR_W(16)) bus();

    nes_bus_ctrl #(.RESET_CYCLES(RC), .ADDR_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .running (running),
        .brk_hit (brk_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scripted CPU: LDA #$01 / STA $30 / JMP $8000, advancing only while cpu_ready
    logic [15:0] p_addr [8];
    bit          p_sync [8];
    bit          p_we   [8];
    bit [7:0]    tb_mem [65536];
    int          cidx;

    task automatic drive_cpu();
        bus.cpu_addr  = p_addr[cidx];
        bus.cpu_sync  = p_sync[cidx];
        bus.cpu_write = p_we[cidx];
        bus.cpu_dout  = 8'h01;
    endtask

    initial begin
        logic        adv, rst, mw;
        logic [15:0] ma;
        logic [7:0]  mi;
        p_addr = '{16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h0030, 16'h8004, 16'h8005, 16'h8006};
        p_sync = '{1, 0, 1, 0, 0, 1, 0, 0};
        p_we   = '{0, 0, 0, 0, 1, 0, 0, 0};
        cidx = 0;
        bus.mem_out = 8'h00;
        drive_cpu();
        forever begin
            @(negedge clk);
            adv = bus.cpu_ready; rst = bus.cpu_reset;
            ma = bus.mem_addr; mw = bus.mem_write; mi = bus.mem_in;
            @(posedge clk); #1;
            bus.mem_out = tb_mem[ma];
            if (mw) tb_mem[ma] = mi;
            if (rst) cidx = 0;
            else if (adv) cidx = (cidx + 1) % 8;
            drive_cpu();
        end
    end

    // Reference model: reset countdown, then a queue of host-access cycles, otherwise CPU mode
    bit [7:0]    shadow [65536];
    slot_t       sched [$];
    int          m_rst;
    bit          m_go, m_step, m_moved, m_hit, m_brk_en;
    logic [15:0] m_brk_addr;
    logic [7:0]  m_rdata;

    initial begin
        bit          e_cmd, e_rdy, e_rst, e_we, e_rv, e_run, a_chk, stp, bstp, acc;
        logic [15:0] e_addr;
        logic [7:0]  e_din;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_cpu_reset", bus.cpu_reset, 1);
                chk("rst_cpu_ready", bus.cpu_ready, 0);
                chk("rst_host_ready", bus.host_ready, 0);
                chk("rst_rvalid", bus.host_rvalid, 0);
                chk("rst_rdata", bus.host_rdata, 0);
                chk("rst_mem_write", bus.mem_write, 0);
                chk("rst_brk_hit", brk_hit, 0);
                m_rst = RC; sched.delete(); m_go = 0; m_step = 0; m_moved = 0;
                m_hit = 0; m_brk_en = 0; m_brk_addr = '0; m_rdata = '0;
                continue;
            end
            e_cmd = 0; e_rdy = 0; e_rst = 0; e_we = 0; e_rv = 0; e_run = 0; a_chk = 1;
            stp = 0; bstp = 0;
            e_addr = bus.cpu_addr; e_din = bus.cpu_dout;
            if (m_rst > 0) begin
                e_rst = 1;
            end else if (sched.size() > 0) begin
                case (sched[0].kind)
                    K_WR: begin e_addr = sched[0].a; e_we = 1; e_din = sched[0].d; end
                    K_RD: e_addr = sched[0].a;
                    K_RDW: begin e_rv = 1; a_chk = 0; m_rdata = shadow[sched[0].a]; end
                    default: ;
                endcase
            end else begin
                e_cmd = 1;
                if (m_go) begin
                    e_run = 1;
                    bstp = !m_step && m_brk_en && (bus.cpu_addr == m_brk_addr);
                    stp = m_moved && bus.cpu_sync && (m_step || bstp);
                    e_rdy = !stp;
                    e_we = bus.cpu_write && !stp;
                end
            end
            chk("cpu_reset", bus.cpu_reset, e_rst);
            chk("cpu_ready", bus.cpu_ready, e_rdy);
            chk("host_ready", bus.host_ready, e_cmd);
            chk("mem_write", bus.mem_write, e_we);
            chk("host_rvalid", bus.host_rvalid, e_rv);
            chk("host_rdata", bus.host_rdata, m_rdata);
            chk("running", running, e_run);
            chk("brk_hit", brk_hit, m_hit);
            chk("cpu_din", bus.cpu_din, bus.mem_out);
            if (a_chk) chk("mem_addr", bus.mem_addr, e_addr);
            if (e_we) chk("mem_in", bus.mem_in, e_din);

            if (e_we) shadow[e_addr] = e_din;
            acc = e_cmd && bus.host_valid;
            if (m_rst > 0) begin
                m_rst--;
            end else if (sched.size() > 0) begin
                void'(sched.pop_front());
            end else begin
                if (e_rdy) m_moved = 1;
                if (stp) begin
                    m_go = 0;
                    if (bstp) m_hit = 1;
                end
                if (acc) begin
                    case (bus.host_op)
                        OP_RESET: begin m_rst = RC; m_go = 0; m_hit = 0; end
                        OP_START: begin m_go = 1; m_step = 0; m_moved = 0; m_hit = 0; end
                        OP_PAUSE: m_go = 0;
                        OP_STEP:  begin m_go = 1; m_step = 1; m_moved = 0; m_hit = 0; end
                        OP_WRITE: begin
                            sched.push_back('{K_WR, bus.host_addr, bus.host_wdata});
                            if (m_go) sched.push_back('{K_FILL, 16'h0, 8'h0});
                        end
                        OP_READ: begin
                            sched.push_back('{K_RD, bus.host_addr, 8'h0});
                            sched.push_back('{K_RDW, bus.host_addr, 8'h0});
                            if (m_go) sched.push_back('{K_FILL, 16'h0, 8'h0});
                        end
`ifdef NES_BREAKPOINT_EN
                        OP_BRK: begin
                            if (bus.host_wdata[0]) begin
                                m_brk_en = 1; m_brk_addr = bus.host_addr;
                            end else begin
                                m_brk_en = 0;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [7:0] d);
        bit acc = 0;
        bus.host_valid = 1'b1; bus.host_op = op; bus.host_addr = a; bus.host_wdata = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus.host_ready;
            cyc();
        end
        bus.host_valid = 1'b0;
        chk("send_accepted", acc, 1);
    endtask

    task automatic wait_ready(input string name);
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = bus.host_ready;
            cyc();
        end
        chk(name, ok, 1);
    endtask

    initial begin
        int n, seen;
        bit found;
        logic [7:0] got;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen;
        bit found;
        logic [7:0] got;
        bus.host_valid = 1'b0; bus.host_op = '0; bus.host_addr = '0; bus.host_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.cpu_reset) break;
            n++;
        end
        chk("reset_hold_cycles", n, RC);
        chk("paused_host_ready", bus.host_ready, 1);
        chk("paused_cpu_ready", bus.cpu_ready, 0);
        cyc();

        // host write then read while paused
        send(OP_WRITE, 16'h8000, 8'hA9);
        n = 0;
        repeat (4) begin @(negedge clk); if (bus.mem_write) n++; cyc(); end
        chk("wr_pulse_count", n, 1);
        chk("mem_8000", tb_mem[16'h8000], 8'hA9);
        send(OP_READ, 16'h8000, 8'h00);
        @(negedge clk); chk("rd_rvalid_c1", bus.host_rvalid, 0); cyc();
        @(negedge clk); chk("rd_rvalid_c2", bus.host_rvalid, 1);
        chk("rd_rdata", bus.host_rdata, 8'hA9); cyc();
        @(negedge clk); chk("rd_rvalid_c3", bus.host_rvalid, 0);
        chk("rd_rdata_held", bus.host_rdata, 8'hA9); cyc();
        send(8'h7F, 16'h1234, 8'hEE);
        repeat (2) cyc();

        // host accesses preempting a running CPU
        send(OP_START, 16'h0, 8'h0);
        repeat (10) cyc();
        send(OP_WRITE, 16'h0200, 8'h55);
        n = 0;
        repeat (4) begin @(negedge clk); if (!bus.cpu_ready) n++; cyc(); end
        chk("run_wr_stall", n, 2);
        chk("mem_0200", tb_mem[16'h0200], 8'h55);
        send(OP_READ, 16'h0030, 8'h00);
        n = 0; seen = 0; got = '0;
        repeat (5) begin
            @(negedge clk);
            if (!bus.cpu_ready) n++;
            if (bus.host_rvalid) begin seen++; got = bus.host_rdata; end
            cyc();
        end
        chk("run_rd_stall", n, 3);
        chk("run_rd_seen", seen, 1);
        chk("run_rd_cpu_write", got, 8'h01);
        send(OP_PAUSE, 16'h0, 8'h0);
        @(negedge clk); chk("pause_running", running, 0); cyc();

        // single step from the reset vector
        send(OP_RESET, 16'h0, 8'h0);
        wait_ready("reset_done");
        send(OP_STEP, 16'h0, 8'h0);
        n = 0;
        repeat (6) begin @(negedge clk); if (bus.cpu_ready) n++; cyc(); end
        chk("step_ready_cycles", n, 2);
        @(negedge clk);
        chk("step_running", running, 0);
        chk("step_stop_addr", bus.cpu_addr, 16'h8002);
        cyc();

        // RESET_CPU in the middle of an instruction
        send(OP_START, 16'h0, 8'h0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = (bus.cpu_addr == 16'h8003);
            cyc();
        end
        chk("mid_found", found, 1);
        send(OP_RESET, 16'h0, 8'h0);
        @(negedge clk);
        chk("mid_cpu_reset", bus.cpu_reset, 1);
        chk("mid_cpu_ready", bus.cpu_ready, 0);
        cyc();
        wait_ready("mid_reset_done");
        @(negedge clk);
        chk("mid_running", running, 0);
        chk("mid_cpu_addr", bus.cpu_addr, 16'h8000);
        cyc();

`ifdef NES_BREAKPOINT_EN
        send(OP_BRK, 16'h8004, 8'h01);
        send(OP_START, 16'h0, 8'h0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = !running;
            if (!found) cyc();
        end
        chk("brk_stopped", found, 1);
        chk("brk_addr_hold", bus.cpu_addr, 16'h8004);
        chk("brk_hit_set", brk_hit, 1);
        cyc();
        send(OP_START, 16'h0, 8'h0);
        @(negedge clk);
        chk("brk_cleared", brk_hit, 0);
        chk("brk_resume_ready", bus.cpu_ready, 1);
        cyc();
        @(negedge clk); chk("brk_past", bus.cpu_addr, 16'h8005); cyc();
        send(OP_BRK, 16'h0000, 8'h00);
        repeat (12) cyc();
        @(negedge clk); chk("brk_disabled_running", running, 1); cyc();
`else
        send(OP_BRK, 16'h8004, 8'h01);
        send(OP_START, 16'h0, 8'h0);
        repeat (12) cyc();
        @(negedge clk);
        chk("nobrk_running", running, 1);
        chk("nobrk_hit", brk_hit, 0);
        cyc();
`endif
        send(OP_PAUSE, 16'h0, 8'h0);
        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
